barrel_shift_arbiter: RTL and testbench

//  Shares one barrel_shifter datapath between NUM_REQ requesters with valid/ready handshakes.

---
 rtl/barrel_shift_pkg.sv | 22 ++
 rtl/barrel_shifter.sv | 25 ++
 rtl/barrel_shift_arbiter.sv | 128 ++++++++++++
 tb/tb_barrel_shift_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_shift_pkg.sv
// Shared types and width helpers for the barrel_shift_arbiter block and its shifter datapath.
package barrel_shift_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int OP_DIR_W   = 1;
  localparam int OP_ARITH_W = 1;
  localparam int OP_COUNT_W = 16;

  // Widths never collapse to zero so a degenerate parameter still yields legal vectors.
  function automatic int sa_width(input int data_length);
    return (data_length > 1) ? $clog2(data_length) : 1;
  endfunction

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter: left zero fill, right logical zero fill, right arithmetic sign fill.
module barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int DATA_LENGTH = 4,
  localparam int SA_W = sa_width(DATA_LENGTH)
) (
  input  logic [DATA_LENGTH-1:0] data_in,
  input  logic [SA_W-1:0]        sa,
  input  logic                   right,
  input  logic                   arith,
  output logic [DATA_LENGTH-1:0] data_out
);

  always_comb begin
    if (!right) begin
      data_out = data_in << sa;
    end else if (arith) begin
      data_out = $unsigned($signed(data_in) >>> sa);
    end else begin
      data_out = data_in >> sa;
    end
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel_shifter among NUM_REQ valid/ready requesters.
// Optional BSA_OP_COUNT_EN adds a wrapping 16-bit transfer counter output op_count.
module barrel_shift_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int DATA_LENGTH = 4,
  parameter int NUM_REQ     = 2,
  localparam int SA_W = sa_width(DATA_LENGTH),
  localparam int ID_W = id_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_right,
  input  logic [NUM_REQ-1:0]             req_arith,
  input  logic [NUM_REQ*SA_W-1:0]        req_sa,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_LENGTH-1:0]         out_data,
  output logic [ID_W-1:0]                out_id
`ifdef BSA_OP_COUNT_EN
  ,
  output logic [OP_COUNT_W-1:0]          op_count
`endif
);

  // Handshakes: a request transfers on req_valid[i] & req_ready[i]; a result transfers on
  // out_valid & out_ready. Ready never depends on the same requester's data fields.
  state_t                 state, state_next;
  logic [ID_W-1:0]        rr_ptr;
  logic                   can_accept;
  logic                   grant_found;
  logic [ID_W-1:0]        grant_idx;
  int                     cand;
  logic                   transfer;
  logic [DATA_LENGTH-1:0] sel_data;
  logic [SA_W-1:0]        sel_sa;
  logic [OP_DIR_W-1:0]    sel_right;
  logic [OP_ARITH_W-1:0]  sel_arith;
  logic [DATA_LENGTH-1:0] shift_result;

  assign can_accept = (state == ST_IDLE) | (out_valid & out_ready);

  // Priority search starting at rr_ptr, wrapping past NUM_REQ-1 back to 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && can_accept && rst_n && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign transfer = grant_found;

  assign sel_data  = req_data[int'(grant_idx)*DATA_LENGTH +: DATA_LENGTH];
  assign sel_sa    = req_sa[int'(grant_idx)*SA_W +: SA_W];
  assign sel_right = req_right[grant_idx];
  assign sel_arith = req_arith[grant_idx];

  barrel_shifter #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_shifter (
    .data_in (sel_data),
    .sa      (sel_sa),
    .right   (sel_right),
    .arith   (sel_arith),
    .data_out(shift_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (transfer) state_next = ST_HOLD;
      ST_HOLD: if (out_ready) state_next = transfer ? ST_HOLD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_HOLD);
  end

  // Result registers only load on a transfer, so they stay stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else if (transfer) begin
      out_data <= shift_result;
      out_id   <= grant_idx;
      rr_ptr   <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

`ifdef BSA_OP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (transfer) begin
      op_count <= op_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Self-checking bench for barrel_shift_arbiter (DATA_LENGTH=4, NUM_REQ=2), scoreboard based.
module tb_barrel_shift_arbiter;

  localparam int W  = 4;
  localparam int NR = 2;
  localparam int SW = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_right;
  logic [NR-1:0]   req_arith;
  logic [NR*SW-1:0] req_sa;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [0:0]      out_id;
`ifdef BSA_OP_COUNT_EN
  logic [15:0]     op_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard entry: {id, data}; head is the result the DUT should currently hold.
  logic [W:0] exp_q[$];
  logic [W:0] tmp_e;
  logic [1:0] m_rr;
  logic       m_hold;
  int         m_win;
  logic [NR-1:0] exp_ready;

  barrel_shift_arbiter #(.DATA_LENGTH(W), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_right(req_right), .req_arith(req_arith), .req_sa(req_sa),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id)
`ifdef BSA_OP_COUNT_EN
    , .op_count(op_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic r,
                                               input logic a, input logic [SW-1:0] sa);
    logic [W-1:0] res;
    for (int b = 0; b < W; b++) begin
      if (!r) res[b] = (b - int'(sa) >= 0) ? d[b - int'(sa)] : 1'b0;
      else    res[b] = (b + int'(sa) < W) ? d[b + int'(sa)] : (a ? d[W-1] : 1'b0);
    end
    return res;
  endfunction

  always_comb begin
    m_win = -1;
    if (rst_n && (!m_hold || out_ready)) begin
      for (int k = 0; k < NR; k++) begin
        if (m_win < 0 && req_valid[(int'(m_rr) + k) % NR]) m_win = (int'(m_rr) + k) % NR;
      end
    end
    exp_ready = '0;
    if (m_win >= 0) exp_ready[m_win] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rr   <= '0;
      m_hold <= 1'b0;
    end else begin
      if (m_hold && out_ready && exp_q.size() > 0) tmp_e = exp_q.pop_front();
      if (m_win >= 0) begin
        exp_q.push_back({1'(m_win), model_shift(req_data[m_win*W +: W], req_right[m_win],
                                                req_arith[m_win], req_sa[m_win*SW +: SW])});
        m_rr   <= 2'((m_win + 1) % NR);
        m_hold <= 1'b1;
      end else if (m_hold && out_ready) begin
        m_hold <= 1'b0;
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d, input logic r,
                         input logic a, input logic [SW-1:0] sa);
    req_valid[i]        = v;
    req_data[i*W +: W]  = d;
    req_right[i]        = r;
    req_arith[i]        = a;
    req_sa[i*SW +: SW]  = sa;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    set_req(0, 1'b1, 4'hA, 1'b1, 1'b1, 2'd1);
    set_req(1, 1'b1, 4'h5, 1'b0, 1'b0, 2'd2);
    repeat (2) @(posedge clk);
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_bad++; $display("FAIL reset_data: got %h expected 0", out_data); end
    n_cmp++; if (out_id !== 1'b0) begin n_bad++; $display("FAIL reset_id: got %h expected 0", out_id); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    req_valid = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic test_shift_ops();
    logic [W+W+SW+1:0] tbl [5];
    logic [W-1:0] d, e;
    logic r, a;
    logic [SW-1:0] sa;
    // {data, right, arith, sa, expected}
    tbl[0] = {4'b1010, 1'b1, 1'b1, 2'd1, 4'b1101};
    tbl[1] = {4'b1010, 1'b1, 1'b0, 2'd1, 4'b0101};
    tbl[2] = {4'b1010, 1'b0, 1'b1, 2'd1, 4'b0100};
    tbl[3] = {4'b1010, 1'b1, 1'b1, 2'd3, 4'b1111};
    tbl[4] = {4'b1010, 1'b1, 1'b1, 2'd0, 4'b1010};
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      {d, r, a, sa, e} = tbl[t];
      set_req(0, 1'b1, d, r, a, sa);
      #1;
      n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL shift_ready: got %b expected %b", req_ready, exp_ready); end
      @(posedge clk); #2;
      req_valid = '0;
      #1;
      n_cmp++; if (out_valid !== m_hold) begin n_bad++; $display("FAIL shift_valid: got %b expected %b", out_valid, m_hold); end
      n_cmp++; if ({out_id, out_data} !== exp_q[0]) begin n_bad++; $display("FAIL shift_sb: got %h expected %h", {out_id, out_data}, exp_q[0]); end
      n_cmp++; if (out_data !== e || out_id !== 1'b0) begin n_bad++; $display("FAIL shift_const%0d: got %b/%0d expected %b/0", t, out_data, out_id, e); end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_round_robin();
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      set_req(0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      set_req(1, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      if (c == 8) req_valid = '0;
      #1;
      n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rr_ready: got %b expected %b", req_ready, exp_ready); end
      if (c > 0) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid_held: got %b expected 1", out_valid); end
        n_cmp++; if (out_id !== 1'(c)) begin n_bad++; $display("FAIL rr_alternate: got %0d expected %0d", out_id, c % 2); end
        n_cmp++; if ({out_id, out_data} !== exp_q[0]) begin n_bad++; $display("FAIL rr_sb: got %h expected %h", {out_id, out_data}, exp_q[0]); end
      end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] held;
    out_ready = 1'b1;
    set_req(0, 1'b1, 4'b0110, 1'b0, 1'b0, 2'd1);
    #1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    set_req(0, 1'b1, 4'b1001, 1'b1, 1'b1, 2'd2);
    set_req(1, 1'b1, 4'b0011, 1'b0, 1'b0, 2'd2);
    #1;
    held = {out_id, out_data};
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL bp_ready: got %b expected 00", req_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
      n_cmp++; if ({out_id, out_data} !== exp_q[0] || {out_id, out_data} !== held) begin n_bad++; $display("FAIL bp_stable: got %h expected %h", {out_id, out_data}, exp_q[0]); end
      @(posedge clk); #3;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL bp_accept_ready: got %b expected %b", req_ready, exp_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    #1;
    n_cmp++; if ({out_id, out_data} !== exp_q[0]) begin n_bad++; $display("FAIL bp_next_sb: got %h expected %h", {out_id, out_data}, exp_q[0]); end
    @(posedge clk); #2;
  endtask

  task automatic test_drop_valid();
    out_ready = 1'b1;
    set_req(0, 1'b1, 4'b1100, 1'b1, 1'b0, 2'd2);
    @(posedge clk); #2;
    out_ready = 1'b0;
    set_req(1, 1'b1, 4'b0111, 1'b0, 1'b0, 2'd1);
    repeat (2) @(posedge clk);
    #2;
    req_valid[1] = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL drop_only_req0: got %b expected 01", req_ready); end
    @(posedge clk); #2;
    set_req(1, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3);
    #1;
    n_cmp++; if (req_ready !== 2'b10) begin n_bad++; $display("FAIL drop_rr_kept: got %b expected 10", req_ready); end
    n_cmp++; if ({out_id, out_data} !== exp_q[0]) begin n_bad++; $display("FAIL drop_sb: got %h expected %h", {out_id, out_data}, exp_q[0]); end
    @(posedge clk); #2;
    req_valid = '0;
    #1;
    n_cmp++; if ({out_id, out_data} !== exp_q[0]) begin n_bad++; $display("FAIL drop_sb2: got %h expected %h", {out_id, out_data}, exp_q[0]); end
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b1;
    req_valid = '0;
    set_req(1, 1'b1, 4'b1010, 1'b0, 1'b0, 2'd1);
    @(posedge clk); #2;
    out_ready = 1'b0;
    #1;
    n_cmp++; if (out_data !== 4'b0100 || out_id !== 1'b1) begin n_bad++; $display("FAIL mid_setup: got %b/%0d expected 0100/1", out_data, out_id); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0 || out_id !== 1'b0) begin n_bad++; $display("FAIL mid_rst_data: got %h/%0d expected 0/0", out_data, out_id); end
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 00", req_ready); end
    @(posedge clk); #2;
    req_valid = '0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk); #2;
  endtask

`ifdef BSA_OP_COUNT_EN
  task automatic test_op_count();
    out_ready = 1'b1;
    n_cmp++; if (op_count !== 16'd0) begin n_bad++; $display("FAIL cnt_reset: got %0d expected 0", op_count); end
    set_req(0, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd1);
    repeat (5) @(posedge clk);
    #2;
    req_valid = '0;
    #1;
    n_cmp++; if (op_count !== 16'd5) begin n_bad++; $display("FAIL cnt_five: got %0d expected 5", op_count); end
    req_valid[0] = 1'b1;
    repeat (65530) @(posedge clk);
    #2;
    req_valid = '0;
    #1;
    n_cmp++; if (op_count !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_max: got %h expected ffff", op_count); end
    req_valid[0] = 1'b1;
    @(posedge clk); #2;
    req_valid = '0;
    #1;
    n_cmp++; if (op_count !== 16'h0000) begin n_bad++; $display("FAIL cnt_wrap: got %h expected 0000", op_count); end
    @(posedge clk); #2;
  endtask
`endif

  initial begin
    req_valid = '0; req_data = '0; req_right = '0; req_arith = '0; req_sa = '0;
    out_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_shift_ops();
    test_round_robin();
    test_backpressure();
    test_drop_valid();
    test_reset_mid_hold();
`ifdef BSA_OP_COUNT_EN
    test_op_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
